// File: rtl/demux14_tdm_if.sv
// Bus bundle for the 1-to-4 TDM demultiplexer: serial sample input side
// plus the four rebuilt channels and their status pulses.
interface demux14_tdm_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          din_valid;
    logic          sof;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic          frame_valid;
    logic          locked;
    logic          err;

    modport master (
        output din, din_valid, sof,
        input  a, b, c, d, frame_valid, locked, err
    );

    modport slave (
        input  din, din_valid, sof,
        output a, b, c, d, frame_valid, locked, err
    );
endinterface

// File: rtl/demux14_tdm.sv
// Time-division 1-to-4 demultiplexer: stages slots 0..2, then publishes all
// four channels together on the slot-3 sample, tracking frame sync with sof.
module demux14_tdm #(
    parameter int DW = 8
) (
    input  logic         clk,
    input  logic         rst,
    demux14_tdm_if.slave bus
);
    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    slot;
    logic [1:0]    slot_next;
    logic [DW-1:0] stage0;
    logic [DW-1:0] stage1;
    logic [DW-1:0] stage2;

    logic          wr_stage;
    logic [1:0]    wr_idx;
    logic          load_frame;
    logic          err_next;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            slot  <= 2'd0;
        end else begin
            state <= state_next;
            slot  <= slot_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        slot_next  = slot;
        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.sof) begin
                        state_next = SYNC;
                        slot_next  = 2'd1;
                    end
                end
                SYNC: begin
                    if (bus.sof && slot != 2'd0) begin
                        // Early frame start restarts the frame on this sample
                        slot_next = 2'd1;
                    end else if (!bus.sof && slot == 2'd0) begin
                        state_next = HUNT;
                        slot_next  = 2'd0;
                    end else begin
                        slot_next = slot + 2'd1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    slot_next  = 2'd0;
                end
            endcase
        end
    end

    // Output / datapath control decode
    always_comb begin
        wr_stage   = 1'b0;
        wr_idx     = 2'd0;
        load_frame = 1'b0;
        err_next   = 1'b0;
        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.sof) begin
                        wr_stage = 1'b1;
                        wr_idx   = 2'd0;
                    end
                end
                SYNC: begin
                    if (bus.sof && slot != 2'd0) begin
                        err_next = 1'b1;
                        wr_stage = 1'b1;
                        wr_idx   = 2'd0;
                    end else if (!bus.sof && slot == 2'd0) begin
                        err_next = 1'b1;
                    end else if (slot == 2'd3) begin
                        load_frame = 1'b1;
                    end else begin
                        wr_stage = 1'b1;
                        wr_idx   = slot;
                    end
                end
                default: begin
                    err_next = 1'b0;
                end
            endcase
        end
    end

    // Staging registers and published channels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage0          <= '0;
            stage1          <= '0;
            stage2          <= '0;
            bus.a           <= '0;
            bus.b           <= '0;
            bus.c           <= '0;
            bus.d           <= '0;
            bus.frame_valid <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            if (wr_stage) begin
                unique case (wr_idx)
                    2'd0:    stage0 <= bus.din;
                    2'd1:    stage1 <= bus.din;
                    default: stage2 <= bus.din;
                endcase
            end
            if (load_frame) begin
                bus.a <= stage0;
                bus.b <= stage1;
                bus.c <= stage2;
                bus.d <= bus.din;
            end
            bus.frame_valid <= load_frame;
            bus.err         <= err_next;
        end
    end

    assign bus.locked = (state == SYNC);

endmodule

// File: tb/tb_demux14_tdm.sv
// Bench for demux14_tdm: directed scenarios with constant expectations plus a
// randomized stream checked against a frame-queue reference model.
module tb_demux14_tdm;
    logic clk;
    logic rst;

    demux14_tdm_if #(.DW(8)) bus ();

    demux14_tdm #(.DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is a queue of accepted samples since sof
    logic       m_sync;
    logic [7:0] q[$];
    logic [7:0] m_a, m_b, m_c, m_d;
    logic       m_fv, m_err;

    task automatic model_reset();
        m_sync = 1'b0;
        q.delete();
        m_a = 8'h00; m_b = 8'h00; m_c = 8'h00; m_d = 8'h00;
        m_fv = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] v, input logic vl, input logic s);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!vl) return;
        if (!m_sync) begin
            if (s) begin
                q.delete();
                q.push_back(v);
                m_sync = 1'b1;
            end
        end else if (s) begin
            if (q.size() != 0) m_err = 1'b1;
            q.delete();
            q.push_back(v);
        end else if (q.size() == 0) begin
            m_err  = 1'b1;
            m_sync = 1'b0;
        end else begin
            q.push_back(v);
            if (q.size() == 4) begin
                m_a = q[0]; m_b = q[1]; m_c = q[2]; m_d = q[3];
                m_fv = 1'b1;
                q.delete();
            end
        end
    endtask

    // Present one input cycle, advance model on the edge, return at edge+1
    task automatic drive(input logic [7:0] v, input logic vl, input logic s);
        bus.din       = v;
        bus.din_valid = vl;
        bus.sof       = s;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(v, vl, s);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        drive(8'h3C, 1'b1, 1'b0);
        drive(8'h5A, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 32'h0) begin
            n_bad++; $display("FAIL reset_abcd: got %h want 00000000", {bus.a, bus.b, bus.c, bus.d});
        end
        n_cmp++;
        if ({bus.locked, bus.frame_valid, bus.err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.locked, bus.frame_valid, bus.err});
        end
        rst = 1'b0;
        drive(8'h77, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.locked, bus.frame_valid, bus.err} !== 3'b000) begin
            n_bad++; $display("FAIL hunt_discard: got %b want 000", {bus.locked, bus.frame_valid, bus.err});
        end
    endtask

    task automatic test_basic_frame();
        drive(8'hA1, 1'b1, 1'b1);
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_bad++; $display("FAIL basic_lock: got %b want 1", bus.locked);
        end
        drive(8'hB2, 1'b1, 1'b0);
        drive(8'hC3, 1'b1, 1'b0);
        n_cmp++;
        if (bus.frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_early_fv: got %b want 0", bus.frame_valid);
        end
        drive(8'hD4, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 32'hA1B2C3D4) begin
            n_bad++; $display("FAIL basic_abcd: got %h want A1B2C3D4", {bus.a, bus.b, bus.c, bus.d});
        end
        n_cmp++;
        if ({bus.frame_valid, bus.err, bus.locked} !== 3'b101) begin
            n_bad++; $display("FAIL basic_flags: got %b want 101", {bus.frame_valid, bus.err, bus.locked});
        end
        drive(8'h00, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.frame_valid, bus.a} !== {1'b0, 8'hA1}) begin
            n_bad++; $display("FAIL basic_fv_pulse: got %b/%h want 0/a1", bus.frame_valid, bus.a);
        end
    endtask

    task automatic test_gap();
        drive(8'hE5, 1'b1, 1'b1);
        drive(8'hF6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 1'b0, 1'b1);
            n_cmp++;
            if ({bus.locked, bus.frame_valid, bus.err} !== 3'b100) begin
                n_bad++; $display("FAIL gap_hold%0d: got %b want 100", i, {bus.locked, bus.frame_valid, bus.err});
            end
        end
        drive(8'h07, 1'b1, 1'b0);
        n_cmp++;
        if (bus.frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL gap_early_fv: got %b want 0", bus.frame_valid);
        end
        drive(8'h18, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {32'hE5F60718, 1'b1}) begin
            n_bad++; $display("FAIL gap_frame: got %h/%b want E5F60718/1", {bus.a, bus.b, bus.c, bus.d}, bus.frame_valid);
        end
    endtask

    task automatic test_early_sof();
        drive(8'h11, 1'b1, 1'b1);
        drive(8'h22, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b1);
        n_cmp++;
        if ({bus.err, bus.frame_valid, bus.locked} !== 3'b101) begin
            n_bad++; $display("FAIL early_err: got %b want 101", {bus.err, bus.frame_valid, bus.locked});
        end
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 32'hE5F60718) begin
            n_bad++; $display("FAIL early_hold: got %h want E5F60718", {bus.a, bus.b, bus.c, bus.d});
        end
        drive(8'h66, 1'b1, 1'b0);
        drive(8'h77, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.a, bus.err, bus.frame_valid} !== {8'hE5, 2'b00}) begin
            n_bad++; $display("FAIL early_mid: got %h/%b want e5/00", bus.a, {bus.err, bus.frame_valid});
        end
        drive(8'h88, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {32'h55667788, 1'b1}) begin
            n_bad++; $display("FAIL early_frame: got %h/%b want 55667788/1", {bus.a, bus.b, bus.c, bus.d}, bus.frame_valid);
        end
    endtask

    task automatic test_missing_sof();
        drive(8'h99, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.err, bus.locked, bus.frame_valid} !== 3'b100) begin
            n_bad++; $display("FAIL missing_err: got %b want 100", {bus.err, bus.locked, bus.frame_valid});
        end
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 32'h55667788) begin
            n_bad++; $display("FAIL missing_hold: got %h want 55667788", {bus.a, bus.b, bus.c, bus.d});
        end
        for (int i = 0; i < 4; i++) begin
            drive(8'h40 + 8'(i), 1'b1, 1'b0);
            n_cmp++;
            if ({bus.err, bus.locked, bus.frame_valid} !== 3'b000) begin
                n_bad++; $display("FAIL missing_ignore%0d: got %b want 000", i, {bus.err, bus.locked, bus.frame_valid});
            end
        end
        drive(8'h12, 1'b1, 1'b1);
        drive(8'h34, 1'b1, 1'b0);
        drive(8'h56, 1'b1, 1'b0);
        drive(8'h78, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid, bus.locked} !== {32'h12345678, 2'b11}) begin
            n_bad++; $display("FAIL missing_resync: got %h/%b want 12345678/11", {bus.a, bus.b, bus.c, bus.d}, {bus.frame_valid, bus.locked});
        end
    endtask

    task automatic test_mid_reset();
        drive(8'h10, 1'b1, 1'b1);
        drive(8'h20, 1'b1, 1'b0);
        drive(8'h30, 1'b1, 1'b0);
        rst = 1'b1;
        model_reset();
        #2;
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.locked} !== 33'h0) begin
            n_bad++; $display("FAIL midrst_async: got %h/%b want 00000000/0", {bus.a, bus.b, bus.c, bus.d}, bus.locked);
        end
        drive(8'h40, 1'b1, 1'b0);
        rst = 1'b0;
        drive(8'hC1, 1'b1, 1'b1);
        drive(8'hC2, 1'b1, 1'b0);
        drive(8'hC3, 1'b1, 1'b0);
        drive(8'hC4, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid, bus.err} !== {32'hC1C2C3C4, 2'b10}) begin
            n_bad++; $display("FAIL midrst_frame: got %h/%b want C1C2C3C4/10", {bus.a, bus.b, bus.c, bus.d}, {bus.frame_valid, bus.err});
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic       vl, s;
        for (int i = 0; i < 600; i++) begin
            v  = 8'($urandom);
            vl = ($urandom_range(0, 9) < 7);
            if (!m_sync) s = ($urandom_range(0, 9) < 3);
            else if ($urandom_range(0, 19) == 0) s = (q.size() != 0);
            else s = (q.size() == 0);
            drive(v, vl, s);
            n_cmp++;
            if ({bus.a, bus.b, bus.c, bus.d} !== {m_a, m_b, m_c, m_d}) begin
                n_bad++; $display("FAIL rand_abcd[%0d]: got %h want %h", i, {bus.a, bus.b, bus.c, bus.d}, {m_a, m_b, m_c, m_d});
            end
            n_cmp++;
            if ({bus.frame_valid, bus.err, bus.locked} !== {m_fv, m_err, m_sync}) begin
                n_bad++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {bus.frame_valid, bus.err, bus.locked}, {m_fv, m_err, m_sync});
            end
            n_cmp++;
            if ((bus.frame_valid & bus.err) !== 1'b0) begin
                n_bad++; $display("FAIL rand_excl[%0d]: got fv&err=%b want 0", i, bus.frame_valid & bus.err);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_gap();
        test_early_sof();
        test_missing_sof();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/demux14_tdm.md
Name: demux14_tdm

Overview:
Time-division 1-to-4 demultiplexer, the receive-side counterpart of the 4:1 mux. A serial stream of samples arrives on din, one sample per slot, four slots per frame. A frame marker (sof) on slot 0 keeps the block in sync. The block rebuilds the four channels a, b, c, d into registered outputs and updates them once per complete frame.

Parameters:
DW, 8, width of each sample and of each channel output.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous reset, active-high.
din  input  DW  serial sample stream.
din_valid  input  1  din carries a sample this cycle.
sof  input  1  start of frame; qualified by din_valid; marks a slot-0 sample.
a  output  DW  channel 0 (slot 0) of the last complete frame.
b  output  DW  channel 1 (slot 1).
c  output  DW  channel 2 (slot 2).
d  output  DW  channel 3 (slot 3).
frame_valid  output  1  one-cycle pulse: a..d were just updated.
locked  output  1  high while in SYNC state.
err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset, asynchronous: a=b=c=d=0, frame_valid=0, err=0, locked=0, state=HUNT, slot counter=0, staging registers=0.
- Internal state:
  - 2-bit slot counter: the next expected slot.
  - Three DW-bit staging registers for slots 0..2.
  - FSM with states HUNT and SYNC.
- din_valid=0: nothing changes. The slot counter and staging registers hold, and frame_valid and err are 0.
- HUNT:
  - Samples with sof=0 are discarded.
  - din_valid&sof: store din in staging[0], set slot to 1, go to SYNC.
- SYNC, din_valid=1, normal case (sof==(slot==0)):
  - slot 0..2: write din to staging[slot], then slot+1.
  - slot 3: on the same edge, load a<=staging[0], b<=staging[1], c<=staging[2], d<=din. Pulse frame_valid for 1 cycle and wrap slot to 0.
  - Latency: a..d and frame_valid are visible in the cycle after the slot-3 sample is accepted.
- SYNC, sof=1 with slot!=0 (early frame start):
  - Pulse err.
  - Drop the partial frame; a..d keep their old values.
  - Treat the current sample as slot 0: write staging[0] and set slot=1. Stay in SYNC.
- SYNC, sof=0 with slot==0 (missing frame marker):
  - Pulse err, drop the sample, go to HUNT, set slot=0.
  - a..d keep their old values.
- frame_valid and err are never high in the same cycle.
- locked=1 exactly while the state is SYNC. It is a registered output and follows the state register.
- a..d hold their values indefinitely between complete frames, including through HUNT.
- Reset asserted mid-frame: the block returns to reset values at once and discards any partial frame. After rst is released, the first accepted sample needs sof=1.
- din_valid can be deasserted between any two slots; gaps do not break sync.

Test Plan:
- Reset, then stream A1,B2,C3,D4 with din_valid=1 every cycle and sof on A1 -> locked=1 after the A1 edge. One cycle after D4: a=A1, b=B2, c=C3, d=D4, frame_valid=1 for 1 cycle. No err.
- Same frame with din_valid=0 for 3 cycles between B2 and C3 -> same outputs. frame_valid pulses only after D4. locked stays 1.
- After a good frame, send 11,22 then sof on 55, then 66,77,88 -> err pulse on the 55 edge. a..d unchanged until 88. After 88: a=55, b=66, c=77, d=88.
- After a good frame, send 99 with sof=0 at slot 0 -> err pulse, locked=0, a..d unchanged. Further samples with sof=0 are ignored until sof=1.
- Before reset is released, samples without sof -> all outputs 0, locked=0, no pulses.
- Assert rst mid-frame after slot 2 -> a..d=0 and locked=0 right away, with no clock edge needed. A following full frame with sof decodes correctly.
